// File: rtl/cra_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : cra_pipe_addsub
// Description : Pipelined carry-ripple adder/subtractor. A WIDTH-bit operation
//               is split into STAGES equal segments of WIDTH/STAGES bits. Each
//               pipeline stage adds one segment and registers the carry for
//               the next stage. Valid/ready handshakes on both sides, one
//               operation per cycle when not stalled.
// Ports       : clk, rst (async, active-high)
//               in_valid / in_ready / a / b / cin / sub  - operand beat
//               out_valid / out_ready / sum / cout / ovf / zero - result beat
//               sub=0: a+b+cin ; sub=1: a-b (cin ignored)
//               cout: carry out of MSB (sub=1: 1 means no borrow)
//               ovf : signed overflow ; zero: sum == 0
// Revision    : 1.0 - initial release
// ============================================================================
module cra_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_seg = (STAGES >= 1) ? (WIDTH / STAGES) : 1;

    generate
        if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
            $error("cra_pipe_addsub: STAGES must be >= 1 and divide WIDTH");
        end
    endgenerate

    // Stage registers. Index k holds the result of stage k.
    logic             r_v   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];   // sums produced so far (segments 0..k valid)
    logic             r_c   [STAGES];   // carry out of segment k
    logic [WIDTH-1:0] r_a   [STAGES];   // operands travel with the beat
    logic [WIDTH-1:0] r_b   [STAGES];
    logic             r_sub [STAGES];
    logic             r_ovf;

    // Inputs seen by each stage: the port beat for stage 0, else stage k-1.
    logic             w_v_src   [STAGES];
    logic [WIDTH-1:0] w_s_src   [STAGES];
    logic             w_c_src   [STAGES];
    logic [WIDTH-1:0] w_a_src   [STAGES];
    logic [WIDTH-1:0] w_b_src   [STAGES];
    logic             w_sub_src [STAGES];

    logic [WIDTH-1:0] w_s_next [STAGES];
    logic             w_c_next [STAGES];
    logic [c_seg-1:0] w_aseg;
    logic [c_seg-1:0] w_bseg;
    logic [c_seg-1:0] w_sseg;
    logic             w_cmsb;
    logic             w_ovf_next;
    logic             w_adv;

    // The whole pipe moves together; it only stalls when the output beat is
    // presented and not taken.
    assign w_adv    = !r_v[STAGES-1] || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        w_aseg     = '0;
        w_bseg     = '0;
        w_sseg     = '0;
        w_cmsb     = 1'b0;
        w_ovf_next = 1'b0;

        w_v_src[0]   = in_valid;
        w_s_src[0]   = '0;
        // Subtraction is a + ~b + 1, so the initial carry is forced to 1.
        w_c_src[0]   = sub | cin;
        w_a_src[0]   = a;
        w_b_src[0]   = b;
        w_sub_src[0] = sub;
        for (int k = 1; k < STAGES; k++) begin
            w_v_src[k]   = r_v[k-1];
            w_s_src[k]   = r_s[k-1];
            w_c_src[k]   = r_c[k-1];
            w_a_src[k]   = r_a[k-1];
            w_b_src[k]   = r_b[k-1];
            w_sub_src[k] = r_sub[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            w_aseg = w_a_src[k][k*c_seg +: c_seg];
            w_bseg = w_b_src[k][k*c_seg +: c_seg] ^ {c_seg{w_sub_src[k]}};
            {w_c_next[k], w_sseg} = {1'b0, w_aseg} + {1'b0, w_bseg}
                                  + {{c_seg{1'b0}}, w_c_src[k]};
            w_s_next[k] = w_s_src[k];
            w_s_next[k][k*c_seg +: c_seg] = w_sseg;
        end

        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
        w_cmsb = w_a_src[STAGES-1][WIDTH-1]
               ^ (w_b_src[STAGES-1][WIDTH-1] ^ w_sub_src[STAGES-1])
               ^ w_s_next[STAGES-1][WIDTH-1];
        w_ovf_next = w_cmsb ^ w_c_next[STAGES-1];
    end

    // Valid bits and sum/carry chain; reset so the output stage comes up clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_v_src[k];
                r_s[k] <= w_s_next[k];
                r_c[k] <= w_c_next[k];
            end
            r_ovf <= w_ovf_next;
        end
    end

    // Operand payload: meaningless without the matching valid bit, no reset.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= w_a_src[k];
                r_b[k]   <= w_b_src[k];
                r_sub[k] <= w_sub_src[k];
            end
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;
    assign zero      = (r_s[STAGES-1] == '0);

endmodule
`default_nettype wire
